regfile_wb_sequencer: RTL
=========================

// Module: regfile_wb_sequencer
// PURPOSE
//  Write-port controller for register_file: zeroes all registers after reset or on request, then
//  shares the single write port between two write-back requesters (wb0, wb1) with round-robin
//  arbitration and valid/ready handshakes. Drives write_en/waddr/wdata of the register file.
// PARAMETERS
//  DATA_WIDTH     64  register width in bits
//  LOG2_NUM_REGS  5   register address width
//  NUM_REGS       32  implemented registers; must be <= 2**LOG2_NUM_REGS
// PORTS
//  clk          in   1              single clock, rising edge
//  reset        in   1              asynchronous, active-high reset
//  clear_req    in   1              one-cycle request to zero all registers
//  busy         out  1              1 while clear sweep is in progress
//  wb0_valid    in   1              requester 0 has a write
//  wb0_ready    out  1              requester 0 write accepted this cycle if valid
//  wb0_addr     in   LOG2_NUM_REGS  requester 0 destination register
//  wb0_data     in   DATA_WIDTH     requester 0 write data
//  wb1_valid    in   1              requester 1 has a write
//  wb1_ready    out  1              requester 1 write accepted this cycle if valid
//  wb1_addr     in   LOG2_NUM_REGS  requester 1 destination register
//  wb1_data     in   DATA_WIDTH     requester 1 write data
//  rf_write_en  out  1              to register_file write_en
//  rf_waddr     out  LOG2_NUM_REGS  to register_file waddr
//  rf_wdata     out  DATA_WIDTH     to register_file wdata
//  wb_addr_err  out  1              one-cycle pulse: accepted write had addr >= NUM_REGS
// BEHAVIOUR
//  - Reset values: state=CLEAR, clr_cnt=0, last_grant=1, rf_write_en=0, rf_waddr=0, rf_wdata=0,
//    wb_addr_err=0; busy=1 and both readies=0 while reset is asserted.
//  - rf_* and wb_addr_err are registered. A write accepted or a clear step issued in cycle t
//    appears on rf_* in cycle t+1. rf_write_en is 0 in any cycle with nothing issued in t.
//  - States: CLEAR, ARB. busy = (state==CLEAR). It is decoded from the state register.
//  - CLEAR: each cycle issue a write of waddr=clr_cnt and wdata=0, then clr_cnt++. Both readies
//    are 0 and clear_req is ignored. When clr_cnt==NUM_REGS-1 is issued, go to ARB and reset
//    clr_cnt to 0. Exactly NUM_REGS clear writes are issued, to ascending addresses 0..NUM_REGS-1.
//  - ARB with clear_req=1: both readies=0, no grant, go to CLEAR next cycle. clear_req beats requests.
//  - ARB with clear_req=0: readies are combinational from state, clear_req, both valids and last_grant.
//    Only wb0 valid: wb0_ready=1. Only wb1 valid: wb1_ready=1.
//    Both valid: grant the requester that is not last_grant. At most one ready is high per cycle.
//  - An accepted write sets last_grant to the granted requester. last_grant is unchanged when idle.
//  - Accepted write with addr < NUM_REGS: rf_write_en=1, with the accepted addr and data, in the next cycle.
//    With addr >= NUM_REGS: the write is still accepted, rf_write_en stays 0, and wb_addr_err=1
//    for 1 cycle.
//  - Back-to-back accepts are allowed (one per cycle, full throughput).
//  - CLEAR->ARB: readies may rise in the cycle the last clear write is on rf_*. No port conflict.
//  - Reset mid-operation: all outputs return to reset values immediately (asynchronous). The sweep
//    restarts from address 0 on the first clock edge after reset deasserts.
// TESTING
//  1. Deassert reset -> 32 cycles rf_write_en=1, waddr 0..31, wdata=0; busy falls after last issue.
//  2. After clear, wb0 addr=5 data=64'hDEAD for 1 cycle -> wb0_ready=1; next cycle write_en=1,
//     waddr=5, wdata=64'hDEAD.
//  3. Both valid for 4 cycles with distinct data -> grants wb0,wb1,wb0,wb1, rf_* follows each by 1 cycle.
//  4. clear_req while both valid -> readies 0 that cycle, then 32 zero writes with busy=1, then
//     arbitration resumes.
//  5. reset pulsed when clr_cnt=10 -> rf_write_en=0 at once; after release sweep restarts at waddr 0.
//  6. NUM_REGS=24: wb1 addr=30 -> accepted, rf_write_en=0 next cycle, wb_addr_err=1 for one cycle.

Source files
------------

// File: rtl/regfile_wb_sequencer.sv
// regfile_wb_sequencer
//   Write-port controller for a register file. After reset, or on clear_req,
//   it sweeps zeroes into every implemented register. Otherwise it shares the
//   single write port between two write-back requesters (wb0, wb1). Arbitration
//   is round-robin, and each requester uses a valid/ready handshake.
//
// Ports
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   clear_req               one-cycle request to zero all registers
//   busy                    high while the clear sweep is running
//   wbN_valid/ready         handshake for requester N (N = 0, 1)
//   wbN_addr/data           destination register and data for requester N
//   rf_write_en/waddr/wdata registered write port to the register file
//   wb_addr_err             one-cycle pulse: an accepted write targeted a
//                           register at or above NUM_REGS
module regfile_wb_sequencer #(
  parameter int DATA_WIDTH    = 64,
  parameter int LOG2_NUM_REGS = 5,
  parameter int NUM_REGS      = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_req,
  output logic                     busy,
  input  logic                     wb0_valid,
  output logic                     wb0_ready,
  input  logic [LOG2_NUM_REGS-1:0] wb0_addr,
  input  logic [DATA_WIDTH-1:0]    wb0_data,
  input  logic                     wb1_valid,
  output logic                     wb1_ready,
  input  logic [LOG2_NUM_REGS-1:0] wb1_addr,
  input  logic [DATA_WIDTH-1:0]    wb1_data,
  output logic                     rf_write_en,
  output logic [LOG2_NUM_REGS-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  output logic                     wb_addr_err
);

  typedef enum logic {CLEAR, ARB} state_t;

  // The range check uses one extra bit, so NUM_REGS == 2**LOG2_NUM_REGS is representable.
  localparam logic [LOG2_NUM_REGS-1:0] LAST_IDX   = LOG2_NUM_REGS'(NUM_REGS - 1);
  localparam logic [LOG2_NUM_REGS:0]   NUM_REGS_W = (LOG2_NUM_REGS + 1)'(NUM_REGS);

  state_t                     state_q, state_d;
  logic [LOG2_NUM_REGS-1:0]   clr_cnt_q, clr_cnt_d;
  logic                       last_grant_q, last_grant_d;  // 0 = wb0, 1 = wb1
  logic                       rf_write_en_q, rf_write_en_d;
  logic [LOG2_NUM_REGS-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0]      rf_wdata_q, rf_wdata_d;
  logic                       wb_addr_err_q, wb_addr_err_d;
  logic [LOG2_NUM_REGS-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]      sel_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= CLEAR;
      clr_cnt_q     <= '0;
      last_grant_q  <= 1'b1;
      rf_write_en_q <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      wb_addr_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      last_grant_q  <= last_grant_d;
      rf_write_en_q <= rf_write_en_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      wb_addr_err_q <= wb_addr_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    last_grant_d  = last_grant_q;
    rf_write_en_d = 1'b0;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    wb_addr_err_d = 1'b0;
    wb0_ready     = 1'b0;
    wb1_ready     = 1'b0;
    sel_addr      = wb0_addr;
    sel_data      = wb0_data;

    case (state_q)
      CLEAR: begin
        rf_write_en_d = 1'b1;
        rf_waddr_d    = clr_cnt_q;
        rf_wdata_d    = '0;
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = ARB;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + LOG2_NUM_REGS'(1);
        end
      end
      ARB: begin
        if (clear_req) begin
          // A clear request takes priority over pending writes. Nothing is granted this cycle.
          state_d = CLEAR;
        end else begin
          if (wb0_valid && wb1_valid) begin
            // Both requesters are valid: grant the one that did not win last time.
            wb0_ready = last_grant_q;
            wb1_ready = ~last_grant_q;
          end else begin
            wb0_ready = wb0_valid;
            wb1_ready = wb1_valid;
          end
          if (wb1_ready) begin
            sel_addr = wb1_addr;
            sel_data = wb1_data;
          end
          if (wb0_ready || wb1_ready) begin
            last_grant_d = wb1_ready;
            // Out-of-range writes are still accepted. They are dropped and flagged instead of written.
            if ({1'b0, sel_addr} < NUM_REGS_W) begin
              rf_write_en_d = 1'b1;
              rf_waddr_d    = sel_addr;
              rf_wdata_d    = sel_data;
            end else begin
              wb_addr_err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign busy        = (state_q == CLEAR);
  assign rf_write_en = rf_write_en_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign wb_addr_err = wb_addr_err_q;

endmodule
